lgdst_ts_sertx: RTL

- Transmit-side counterpart of the serial TS receive glue.
- Accepts TS packet bytes from the Atmel-side byte interface (valid/ready, start-of-packet flag) and buffers them in a small FIFO.
- Serialises 188-byte packets MSB-first onto a 1-bit serial TS bus (ts_clk, ts_d0, ts_valid, ts_sync) toward the modulator.
- ts_clk is a divided, free-running copy of clk; data changes on the ts_clk rising edge so the far end samples on the falling edge.

---
 rtl/lgdst_ts_pkg.sv | 14 +
 rtl/lgdst_ts_sertx_if.sv | 23 ++
 rtl/lgdst_sfifo.sv | 54 +++++
 rtl/lgdst_ts_sertx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lgdst_ts_pkg.sv
// rtl/lgdst_ts_pkg.sv - shared constants and FSM state type for the serial TS transmitter
package lgdst_ts_pkg;

  localparam int         PKT_LEN   = 188;
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    HUNT,
    SEND,
    STALL,
    GAP
  } ts_state_e;

endpackage

// File: rtl/lgdst_ts_sertx_if.sv
// rtl/lgdst_ts_sertx_if.sv - byte stream handshake between the host side and the TS serialiser
interface lgdst_ts_sertx_if;

  logic [7:0] in_data;
  logic       in_sop;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_sop,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_sop,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/lgdst_sfifo.sv
// rtl/lgdst_sfifo.sv - synchronous show-ahead FIFO with full/empty flags
module lgdst_sfifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // a pop in the same cycle frees the slot, so a full FIFO may still take a write
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // storage array, no reset needed since count guards every read
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lgdst_ts_sertx.sv
// rtl/lgdst_ts_sertx.sv - buffers TS packet bytes and serialises them MSB first onto a 1-bit TS bus
module lgdst_ts_sertx #(
  parameter int         CLK_DIV    = 4,
  parameter int         PKT_LEN    = lgdst_ts_pkg::PKT_LEN,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = lgdst_ts_pkg::SYNC_BYTE,
  parameter int         GAP_BITS   = 8
) (
  input  logic             clk,
  input  logic             rst,
  lgdst_ts_sertx_if.slave  src,
  input  logic             enable,
  output logic             ts_clk,
  output logic             ts_d0,
  output logic             ts_valid,
  output logic             ts_sync,
  output logic             err_sync,
  output logic             underrun
);

  import lgdst_ts_pkg::*;

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(PKT_LEN);
  localparam int GW = $clog2(GAP_BITS + 1);

  logic [DW-1:0] div_cnt;
  logic          rise_tick;
  logic          fall_tick;

  ts_state_e     state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;

  logic          fifo_full;
  logic          fifo_empty;
  logic [8:0]    fifo_head;
  logic          head_sop;
  logic [7:0]    head_data;
  logic          last_byte;
  logic          pop;

  assign src.in_ready = ~fifo_full;
  assign head_sop     = fifo_head[8];
  assign head_data    = fifo_head[7:0];
  assign last_byte    = (byte_cnt == BW'(PKT_LEN - 1));
  assign rise_tick    = (div_cnt == DW'(CLK_DIV - 1));
  assign fall_tick    = (div_cnt == DW'(CLK_DIV / 2 - 1));

  lgdst_sfifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (src.in_valid & src.in_ready),
    .wr_data ({src.in_sop, src.in_data}),
    .rd_en   (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // free-running ts_clk: high from rise_tick until fall_tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      ts_clk  <= 1'b0;
    end else begin
      div_cnt <= rise_tick ? '0 : div_cnt + 1'b1;
      if (rise_tick)      ts_clk <= 1'b1;
      else if (fall_tick) ts_clk <= 1'b0;
    end
  end

  // FIFO pop decision, mirrors the byte-consuming branches of the FSM below
  always_comb begin
    pop = 1'b0;
    if (rise_tick && !fifo_empty) begin
      case (state)
        HUNT:    pop = !head_sop || enable;
        SEND:    pop = (bit_cnt == 3'd0) && !last_byte && !head_sop;
        STALL:   pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
  end

  // packet FSM: serial outputs only move on rise_tick; a new byte's bit 7 goes out on the tick it is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      shift    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      ts_d0    <= 1'b0;
      ts_valid <= 1'b0;
      ts_sync  <= 1'b0;
      err_sync <= 1'b0;
      underrun <= 1'b0;
    end else begin
      err_sync <= 1'b0;
      underrun <= 1'b0;
      if (rise_tick) begin
        case (state)
          HUNT: begin
            if (!fifo_empty && head_sop && enable) begin
              state    <= SEND;
              shift    <= head_data;
              bit_cnt  <= 3'd7;
              byte_cnt <= '0;
              ts_d0    <= head_data[7];
              ts_valid <= 1'b1;
              ts_sync  <= 1'b1;
              err_sync <= (head_data != SYNC_BYTE);
            end
          end
          SEND: begin
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              shift   <= {shift[6:0], 1'b0};
              ts_d0   <= shift[6];
            end else if (last_byte || (!fifo_empty && head_sop)) begin
              // packet done or a new sop arrived early: idle for GAP_BITS periods including this one
              state    <= (GAP_BITS == 1) ? HUNT : GAP;
              gap_cnt  <= GW'(GAP_BITS - 2);
              ts_d0    <= 1'b0;
              ts_valid <= 1'b0;
              ts_sync  <= 1'b0;
            end else if (fifo_empty) begin
              state    <= STALL;
              underrun <= 1'b1;
              ts_d0    <= 1'b0;
              ts_valid <= 1'b0;
              ts_sync  <= 1'b0;
            end else begin
              shift    <= head_data;
              bit_cnt  <= 3'd7;
              byte_cnt <= byte_cnt + 1'b1;
              ts_d0    <= head_data[7];
              ts_sync  <= 1'b0;
            end
          end
          STALL: begin
            if (!fifo_empty) begin
              state    <= SEND;
              shift    <= head_data;
              bit_cnt  <= 3'd7;
              byte_cnt <= byte_cnt + 1'b1;
              ts_d0    <= head_data[7];
              ts_valid <= 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == '0) state <= HUNT;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
